// File: rtl/sram_req_adapter.sv
// Adapts a req/gnt + rvalid/rready data port onto a single-port synchronous SRAM.
// Requests take one pipeline stage, then land in a 2-entry response FIFO.
module sram_req_adapter #(
  parameter logic [31:0] BASE_ADDR  = 32'h0010_0000,
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_rvalid_o,
  input  logic                  data_rready_i,
  output logic [31:0]           data_rdata_o,
  output logic                  data_err_o,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [3:0]            BEN,
  output logic [ADDR_WIDTH-1:0] A,
  output logic [31:0]           D,
  input  logic [31:0]           Q
);

  localparam logic [15:0] BASE_HI = BASE_ADDR[31:16];

  function automatic logic in_window(input logic [31:0] addr);
    return (addr[31:16] == BASE_HI);
  endfunction

  logic                  stage_vld_r;
  logic                  stage_rd_r;
  logic                  stage_err_r;
  logic [31:0]           fifo_data_r [2];
  logic [1:0]            fifo_err_r;
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [1:0]            count_r;
  logic [ADDR_WIDTH-1:0] a_hold_r;
  logic [31:0]           d_hold_r;

  logic       pop_s;
  logic       push_s;
  logic [1:0] credits_s;
  logic       gnt_s;
  logic       in_rng_s;
  logic       access_s;
  logic [31:0] push_data_s;
  logic       unused_addr_s;

  assign unused_addr_s = ^data_addr_i[1:0];

  // Gating with rst_n keeps grants and SRAM accesses off while reset is held.
  assign pop_s     = (count_r != 2'd0) && data_rready_i;
  assign push_s    = stage_vld_r;
  assign credits_s = count_r + {1'b0, stage_vld_r};
  assign gnt_s     = rst_n && data_req_i && ((credits_s < 2'd2) || pop_s);
  assign in_rng_s  = in_window(data_addr_i);
  assign access_s  = gnt_s && in_rng_s;
  assign push_data_s = stage_rd_r ? Q : 32'h0000_0000;

  assign data_gnt_o    = gnt_s;
  assign data_rvalid_o = (count_r != 2'd0);

  // Head-of-FIFO response, forced to zero when empty.
  always_comb begin
    data_rdata_o = 32'h0000_0000;
    data_err_o   = 1'b0;
    if (count_r != 2'd0) begin
      data_rdata_o = fifo_data_r[rd_ptr_r];
      data_err_o   = fifo_err_r[rd_ptr_r];
    end else begin
      data_rdata_o = 32'h0000_0000;
      data_err_o   = 1'b0;
    end
  end

  // SRAM pins follow the accepted request in the same cycle; A/D hold otherwise.
  always_comb begin
    CEN  = 1'b1;
    GWEN = 1'b1;
    BEN  = 4'hF;
    A    = a_hold_r;
    D    = d_hold_r;
    if (access_s) begin
      CEN  = 1'b0;
      GWEN = ~data_we_i;
      BEN  = data_we_i ? ~data_be_i : 4'h0;
      A    = data_addr_i[ADDR_WIDTH+1:2];
      D    = data_wdata_i;
    end else begin
      CEN  = 1'b1;
      GWEN = 1'b1;
      BEN  = 4'hF;
      A    = a_hold_r;
      D    = d_hold_r;
    end
  end

  // Last driven SRAM address/data, so idle cycles keep the bus quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hold_r <= '0;
      d_hold_r <= 32'h0000_0000;
    end else if (access_s) begin
      a_hold_r <= data_addr_i[ADDR_WIDTH+1:2];
      d_hold_r <= data_wdata_i;
    end
  end

  // In-flight stage: one cycle where the SRAM read data becomes valid on Q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld_r <= 1'b0;
      stage_rd_r  <= 1'b0;
      stage_err_r <= 1'b0;
    end else begin
      stage_vld_r <= gnt_s;
      stage_rd_r  <= gnt_s && in_rng_s && !data_we_i;
      stage_err_r <= gnt_s && !in_rng_s;
    end
  end

  // Response FIFO; credits on the grant side guarantee it never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_r[i] <= 32'h0000_0000;
      end
      fifo_err_r <= 2'b00;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      count_r    <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= push_data_s;
        fifo_err_r[wr_ptr_r]  <= stage_err_r;
        wr_ptr_r              <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: doc/sram_req_adapter.md
SRAM_REQ_ADAPTER -- requirements
Module: sram_req_adapter

Interface
REQ-001 Parameters SHALL be:
- BASE_ADDR, default 32'h0010_0000: 64 KiB window base; bits [15:0] are ignored.
- ADDR_WIDTH, default 14: SRAM word-address width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_req_i  in  1  request valid.
- data_gnt_o  out  1  request accepted this cycle.
- data_addr_i  in  32  byte address.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables, active high.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  response valid.
- data_rready_i  in  1  response consumed.
- data_rdata_o  out  32  read data.
- data_err_o  out  1  address out of window.
- CEN  out  1  SRAM chip enable, active low.
- GWEN  out  1  SRAM write enable, active low.
- BEN  out  4  SRAM byte enable, active low.
- A  out  ADDR_WIDTH  SRAM word address.
- D  out  32  SRAM write data.
- Q  in  32  SRAM read data, valid the cycle after the access.

Function
REQ-003 Clock and reset SHALL be one clock, clk; reset rst_n SHALL be asynchronous and active-low.
REQ-004 A request SHALL be accepted in cycle N iff data_req_i && data_gnt_o; data_addr_i, data_we_i, data_be_i and data_wdata_i SHALL be held by the requester until accepted.
REQ-005 data_gnt_o SHALL equal data_req_i && (credits < 2 || pop), where:
- credits = in-flight stage occupancy (0/1) + response FIFO count (0..2).
- pop = data_rvalid_o && data_rready_i.
REQ-006 In-range SHALL mean data_addr_i[31:16] == BASE_ADDR[31:16]; bits [1:0] are ignored.
REQ-007 For an accepted in-range request in cycle N, the SRAM pins SHALL be driven combinationally in cycle N as follows:
- CEN=0.
- GWEN=~data_we_i.
- BEN=~data_be_i for writes, 4'b0000 for reads.
- A=data_addr_i[ADDR_WIDTH+1:2].
- D=data_wdata_i.
REQ-008 In any cycle with no accepted in-range request, the SRAM pins SHALL be CEN=1, GWEN=1, BEN=4'hF; A and D SHALL hold their last value.
REQ-009 An out-of-range accepted request SHALL NOT assert CEN and SHALL produce a response with err=1 and rdata=32'h0.
REQ-010 Every accepted request SHALL occupy the in-flight stage in cycle N+1; at the end of N+1 its response SHALL be written to the FIFO as:
- in-range read: rdata=Q, err=0.
- write: rdata=0, err=0.
- out-of-range: rdata=0, err=1.
REQ-011 The response FIFO SHALL be 2 entries deep and in order; data_rvalid_o SHALL be 1 whenever it is non-empty, and data_rdata_o/data_err_o SHALL show the head entry.
REQ-012 Minimum latency SHALL be response valid in cycle N+2; with data_rready_i held at 1, sustained throughput SHALL be one request per cycle.
REQ-013 A response SHALL remain stable while data_rvalid_o && !data_rready_i.
REQ-014 When the FIFO is empty, data_rdata_o SHALL be 0 and data_err_o SHALL be 0.
REQ-015 A simultaneous push and pop SHALL leave the FIFO count unchanged; the FIFO SHALL never overflow, because credits guarantee it.
REQ-016 Byte lanes with data_be_i=0 SHALL NOT be written; a write with data_be_i=4'h0 SHALL still access the SRAM with BEN=4'hF and still return a response.

Reset
REQ-017 While rst_n=0, outputs SHALL be:
- data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0.
- CEN=1, GWEN=1, BEN=4'hF, A=0, D=0.
REQ-018 Reset asserted mid-operation SHALL clear the in-flight stage, the FIFO and the credits; pending responses SHALL be discarded, and no SRAM access SHALL occur in any cycle with rst_n=0.
REQ-019 After rst_n deasserts, the first request SHALL be grantable in the first clock cycle.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Write: addr 32'h0010_0040, be=4'hF, wdata=32'hA5A5_1234 → cycle N shows CEN=0, GWEN=0, BEN=0, A=14'h010; response in N+2 with rdata=0, err=0.
- Read of the same address → A=14'h010, GWEN=1; response in N+2 with rdata=32'hA5A5_1234.
- Byte write: be=4'b0010, wdata=32'h0000_FF00, then read → rdata=32'hA5A5_FF34.
- Out of range: addr 32'h0020_0000 → CEN stays 1; response with err=1, rdata=0.
- Backpressure: rready=0 with 4 reads offered back to back → exactly 2 granted, gnt=0 thereafter; raising rready drains the FIFO in order, then 1 req/cycle resumes.
- Reset mid-burst: rst_n low with FIFO holding 2 entries → rvalid=0 and CEN=1 immediately; no stale response after release.
